// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline hazard controller.
// - REG_ADDR_W : register address width.
// - fwd_sel_e  : EX-stage operand forwarding select encoding.
// - md_state_e : mul/div sequencer state.
// - fwd_sel()  : forwarding select for one EX source operand.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // MEM is younger than WB, so it wins when both write the same register.
  // x0 is hard-wired to zero and is never forwarded.
  function automatic fwd_sel_e fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_m,
    input logic                  we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      return FWD_MEM;
    end
    if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle.
// slave  : hazard controller view (pipeline status in, controls out).
// master : pipeline/testbench view (drives status, observes controls).
// Signals:
//   rs1_d/rs2_d, rs1_e/rs2_e, rd_e/rd_m/rd_w, reg_write_m/w, load_e, pc_src_e
//   md_start_e / md_done : mul/div op in EX / early completion
//   forward_a_e/b_e, stall_f/d/e, flush_d/e/m, md_busy, state_dbg
//   stall_cnt, flush_cnt : saturating performance counters
// Handshake: md_start_e is a level meaning "a mul/div op sits in EX"; it is
// only acted on while the sequencer is idle. md_done is a one-cycle early
// completion strobe, only acted on while busy. Neither has a ready/ack; the
// stall outputs are the back-pressure.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import core_pkg::*;

  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rs1_e;
  logic [REG_ADDR_W-1:0] rs2_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [REG_ADDR_W-1:0] rd_m;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  reg_write_m;
  logic                  reg_write_w;
  logic                  load_e;
  logic                  pc_src_e;
  logic                  md_start_e;
  logic                  md_done;

  fwd_sel_e              forward_a_e;
  fwd_sel_e              forward_b_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  stall_e;
  logic                  flush_d;
  logic                  flush_e;
  logic                  flush_m;
  logic                  md_busy;
  md_state_e             state_dbg;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  reg_write_m, reg_write_w, load_e, pc_src_e, md_start_e, md_done,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
    output flush_d, flush_e, flush_m, md_busy, state_dbg, stall_cnt, flush_cnt
  );

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output reg_write_m, reg_write_w, load_e, pc_src_e, md_start_e, md_done,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
    input  flush_d, flush_e, flush_m, md_busy, state_dbg, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports: clk, rst_n (sync, active-low), inc (count this cycle), q (value).
// The count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline.
// - EX-stage forwarding selects (MEM over WB, x0 never forwarded).
// - Load-use stall, branch/jump flush, multi-cycle mul/div hold in EX.
// - Saturating stall (stall_d) and flush (flush_e) cycle counters.
// Ports: clk, rst_n (sync, active-low), bus (hazard_ctrl_if.slave).
// Parameters: MD_LATENCY (>=2) EX residency of a mul/div op, CNT_W counter width.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  // Countdown only ever holds MD_LATENCY-2 down to 0.
  localparam int                  MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MD_CNT_W-1:0] MD_LOAD  = MD_CNT_W'(MD_LATENCY - 2);

  md_state_e           state_q;
  md_state_e           state_d;
  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_CNT_W-1:0] cnt_d;
  logic                md_stall;
  logic                lw_stall;

  // Sequencer state and countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle itself stalls (IDLE && md_start_e), then MD_LATENCY-2
  // busy cycles count down; the cnt==0 cycle is unstalled, so the op spends
  // exactly MD_LATENCY cycles in EX. md_done releases the stall immediately.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (bus.md_start_e) begin
          state_d  = MD_BUSY;
          cnt_d    = MD_LOAD;
          md_stall = 1'b1;
        end
      end
      MD_BUSY: begin
        if ((cnt_q == '0) || bus.md_done) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d    = cnt_q - MD_CNT_W'(1);
          md_stall = 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // Forwarding, load-use detection and stall/flush priority.
  always_comb begin
    bus.forward_a_e = fwd_sel(bus.rs1_e, bus.rd_m, bus.rd_w,
                              bus.reg_write_m, bus.reg_write_w);
    bus.forward_b_e = fwd_sel(bus.rs2_e, bus.rd_m, bus.rd_w,
                              bus.reg_write_m, bus.reg_write_w);

    lw_stall = bus.load_e && (bus.rd_e != '0) &&
               ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

    bus.stall_f = 1'b0;
    bus.stall_d = 1'b0;
    bus.stall_e = 1'b0;
    bus.flush_d = 1'b0;
    bus.flush_e = 1'b0;
    bus.flush_m = 1'b0;

    if (md_stall) begin
      // Hold everything up to EX and bubble MEM; a branch resolving in the
      // held EX op is re-evaluated once the hold releases.
      bus.stall_f = 1'b1;
      bus.stall_d = 1'b1;
      bus.stall_e = 1'b1;
      bus.flush_m = 1'b1;
    end else if (bus.pc_src_e) begin
      // Redirect kills the dependent load-use pair too, so no stall needed.
      bus.flush_d = 1'b1;
      bus.flush_e = 1'b1;
    end else if (lw_stall) begin
      bus.stall_f = 1'b1;
      bus.stall_d = 1'b1;
      bus.flush_e = 1'b1;
    end
  end

  assign bus.md_busy   = (state_q == MD_BUSY);
  assign bus.state_dbg = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.stall_d),
    .q     (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.flush_e),
    .q     (bus.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Inputs change on the falling edge, the
// combinational outputs are sampled 1 ns later, and the registered counters
// are read on the following falling edge.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int TB_CNT_W = 4;  // small so saturation is reachable quickly
  localparam int TB_MD_LAT = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  hazard_ctrl #(.MD_LATENCY(TB_MD_LAT), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector:
  // {fwd_a[1:0], fwd_b[1:0], stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_busy}
  logic [10:0] obs_vec;
  assign obs_vec = {bus.forward_a_e, bus.forward_b_e, bus.stall_f, bus.stall_d,
                    bus.stall_e, bus.flush_d, bus.flush_e, bus.flush_m, bus.md_busy};

  logic [10:0] exp_q[$];

  function automatic logic [10:0] pack(
    input logic [1:0] fa, input logic [1:0] fb,
    input logic sf, input logic sd, input logic se,
    input logic fd, input logic fe, input logic fm, input logic bsy
  );
    return {fa, fb, sf, sd, se, fd, fe, fm, bsy};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    bus.rs1_d = '0; bus.rs2_d = '0; bus.rs1_e = '0; bus.rs2_e = '0;
    bus.rd_e = '0; bus.rd_m = '0; bus.rd_w = '0;
    bus.reg_write_m = 1'b0; bus.reg_write_w = 1'b0;
    bus.load_e = 1'b0; bus.pc_src_e = 1'b0;
    bus.md_start_e = 1'b0; bus.md_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out(input string tag);
    logic [10:0] e;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs_vec);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      assert (obs_vec === e) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, obs_vec, e);
      end
    end
  endtask

  task automatic step(input string tag, input logic [10:0] e);
    exp_q.push_back(e);
    check_out(tag);
  endtask

  task automatic check_cnt(input string tag, input logic [TB_CNT_W-1:0] es,
                           input logic [TB_CNT_W-1:0] ef);
    n_checks++;
    assert (bus.stall_cnt === es) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, bus.stall_cnt, es);
    end
    n_checks++;
    assert (bus.flush_cnt === ef) else begin
      n_fail++;
      $error("FAIL %s flush_cnt: observed %0d expected %0d", tag, bus.flush_cnt, ef);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic st;
    logic bsy;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    step("reset_outs", pack(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0, 0));
    check_cnt("reset_cnt", 0, 0);

    // 1. Forwarding
    bus.rs1_e = 5; bus.rd_m = 5; bus.reg_write_m = 1'b1; bus.rd_w = 5; bus.reg_write_w = 1'b1;
    step("fwd_mem_prio", pack(FWD_MEM, FWD_RF, 0, 0, 0, 0, 0, 0, 0));
    bus.rd_m = 0;
    step("fwd_rdm0_wb", pack(FWD_WB, FWD_RF, 0, 0, 0, 0, 0, 0, 0));
    bus.rd_m = 5; bus.reg_write_m = 1'b0; bus.rs2_e = 5;
    step("fwd_wb_both", pack(FWD_WB, FWD_WB, 0, 0, 0, 0, 0, 0, 0));
    bus.rs1_e = 0; bus.rs2_e = 9; bus.rd_w = 0; bus.rd_m = 9; bus.reg_write_m = 1'b1;
    step("fwd_x0_and_b_mem", pack(FWD_RF, FWD_MEM, 0, 0, 0, 0, 0, 0, 0));

    // 2. Load-use stall
    do_reset();
    bus.load_e = 1'b1; bus.rd_e = 7; bus.rs2_d = 7;
    step("lw_stall", pack(FWD_RF, FWD_RF, 1, 1, 0, 0, 1, 0, 0));
    @(negedge clk);
    clr_inputs();
    step("lw_release", pack(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0, 0));
    check_cnt("lw_cnt", 1, 1);
    bus.load_e = 1'b1; bus.rd_e = 0;  // rd_e matches rs1_d/rs2_d == x0
    step("lw_rd0_nostall", pack(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    clr_inputs();
    check_cnt("lw_rd0_cnt", 1, 1);

    // 3. Branch flush beats load-use stall
    do_reset();
    bus.pc_src_e = 1'b1; bus.load_e = 1'b1; bus.rd_e = 7; bus.rs1_d = 7;
    step("br_over_lw", pack(FWD_RF, FWD_RF, 0, 0, 0, 1, 1, 0, 0));
    @(negedge clk);
    clr_inputs();
    check_cnt("br_cnt", 0, 1);

    // 4. Full-latency mul/div: 7 stalled cycles, 8th free. Busy covers the
    // seven cycles after the start cycle (countdown 6..0). Cycle 3 also
    // carries a branch plus load-use, cycle 4 a repeated start: both ignored.
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) @(negedge clk);
      clr_inputs();
      bus.md_start_e = (i == 0) || (i == 4);
      if (i == 3) begin
        bus.pc_src_e = 1'b1; bus.load_e = 1'b1; bus.rd_e = 7; bus.rs1_d = 7;
      end
      if (i == 8) bus.md_done = 1'b1;  // idle: ignored
      st  = (i <= 6);
      bsy = (i >= 1) && (i <= 7);
      step($sformatf("md_full_c%0d", i), pack(FWD_RF, FWD_RF, st, st, st, 0, 0, st, bsy));
    end
    @(negedge clk);
    clr_inputs();
    step("md_full_after", pack(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0, 0));
    check_cnt("md_full_cnt", 7, 0);

    // 5. Early completion in the 3rd stalled cycle
    do_reset();
    bus.md_start_e = 1'b1;
    step("md_early_c0", pack(FWD_RF, FWD_RF, 1, 1, 1, 0, 0, 1, 0));
    @(negedge clk);
    clr_inputs();
    step("md_early_c1", pack(FWD_RF, FWD_RF, 1, 1, 1, 0, 0, 1, 1));
    @(negedge clk);
    bus.md_done = 1'b1;
    step("md_early_done", pack(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    bus.md_done = 1'b0;
    step("md_early_idle", pack(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0, 0));
    n_checks++;
    assert (bus.state_dbg === MD_IDLE) else begin
      n_fail++;
      $error("FAIL md_early_state: observed %0d expected %0d", bus.state_dbg, MD_IDLE);
    end
    check_cnt("md_early_cnt", 2, 0);

    // 6. Reset while busy with countdown at 4
    do_reset();
    bus.md_start_e = 1'b1;
    step("md_rst_c0", pack(FWD_RF, FWD_RF, 1, 1, 1, 0, 0, 1, 0));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      clr_inputs();
      if (i == 3) rst_n = 1'b0;  // countdown is 4 here
      step($sformatf("md_rst_c%0d", i), pack(FWD_RF, FWD_RF, 1, 1, 1, 0, 0, 1, 1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    step("md_rst_after", pack(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0, 0));
    check_cnt("md_rst_cnt", 0, 0);

    // Saturation: hold a load-use stall for 20 cycles on 4-bit counters
    do_reset();
    bus.load_e = 1'b1; bus.rd_e = 7; bus.rs1_d = 7;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      step($sformatf("sat_c%0d", i), pack(FWD_RF, FWD_RF, 1, 1, 0, 0, 1, 0, 0));
      if (i == 14) check_cnt("sat_14", 14, 14);
      if (i == 15) check_cnt("sat_15", 15, 15);
    end
    @(negedge clk);
    clr_inputs();
    check_cnt("sat_hold", 15, 15);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
